// File: rtl/pc_pkg.sv
// Shared state encoding and default constants for the fetch-stage PC generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_2000;
  localparam int unsigned DEF_STEP      = 4;
  localparam int unsigned DEF_BOOT_CYC  = 2;
  localparam int unsigned DEF_CNT_W     = 16;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request channel from the PC generator to instruction memory (valid/ready).
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;

  modport master (output req_valid, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_addr, output req_ready);
endinterface

// File: rtl/pc_incr.sv
// Combinational PC successor: pc + STEP, wrapping modulo 2^XLEN.
module pc_incr #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o
);
  assign pc_next_o = pc_i + XLEN'(STEP);
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: redirect visible one cycle later, fire advances by STEP next cycle; stall or
// !req_ready holds the PC. Optional PC_ALIGN_CHECK_EN traps misaligned redirects into HALT.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     STEP      = DEF_STEP,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter int unsigned     BOOT_CYC  = DEF_BOOT_CYC,
  parameter int unsigned     CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             halt,
  input  logic             resume,
  pc_gen_if.master         req,
  output logic [XLEN-1:0]  pc_next,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             halted,
  output logic             misalign
);

  localparam int unsigned     BOOT_W    = (BOOT_CYC < 2) ? 1 : $clog2(BOOT_CYC);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYC - 1);

  pc_state_e         state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, pc_inc;
  logic [BOOT_W-1:0] boot_q, boot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fire;
  logic              bad_redirect;

  pc_incr #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_incr (
    .pc_i      (pc_q),
    .pc_next_o (pc_inc)
  );

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  logic mis_q;

  assign bad_redirect = redirect && |(redirect_pc & ALIGN_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (bad_redirect) begin
      mis_q <= 1'b1;
    end
  end

  assign misalign = mis_q;
`else
  assign bad_redirect = 1'b0;
  assign misalign     = 1'b0;
`endif

  assign req.req_valid = (state_q == RUN) && !stall;
  assign req.req_addr  = pc_q;
  assign fire          = req.req_valid && req.req_ready;

  assign pc_next   = pc_inc;
  assign fetch_cnt = cnt_q;
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    // Counting is independent of redirect: a request firing in the redirect cycle still counts.
    if (fire && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (bad_redirect) begin
      pc_d    = RESET_VEC;
      state_d = HALT;
    end else begin
      if (redirect) begin
        pc_d = redirect_pc;
      end else if (fire) begin
        pc_d = pc_inc;
      end

      unique case (state_q)
        BOOT: begin
          if (boot_q == BOOT_LAST) begin
            state_d = RUN;
          end else begin
            boot_d = boot_q + 1'b1;
          end
        end
        RUN: begin
          if (halt && !redirect) begin
            state_d = HALT;
          end
        end
        HALT: begin
          if (resume || redirect) begin
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      boot_q  <= '0;
      pc_q    <= RESET_VEC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Randomized scoreboard bench for pc_gen against a cycle-level behavioural model.
module tb_pc_gen;
  import pc_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] RVEC    = 32'h0000_2000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0, redirect = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [XLEN-1:0]   redirect_pc = '0;
  logic [XLEN-1:0]   pc_next;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              halted, misalign;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          boot_left;
  bit          m_halt, m_mis;
  logic [31:0] m_pc;
  int          m_cnt;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN)) ifc ();

  pc_gen #(
    .XLEN      (XLEN),
    .STEP      (4),
    .RESET_VEC (RVEC),
    .BOOT_CYC  (2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .resume      (resume),
    .req         (ifc),
    .pc_next     (pc_next),
    .fetch_cnt   (fetch_cnt),
    .halted      (halted),
    .misalign    (misalign)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted request must match the next address the model predicted.
  always @(negedge clk) begin
    if (rst_n && ifc.req_valid && ifc.req_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fire_unexpected: got addr %h expected no fire", ifc.req_addr);
      end else begin
        chk("fire_addr", {32'h0, ifc.req_addr}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  function automatic void model_reset();
    boot_left = 2;
    m_halt    = 1'b0;
    m_mis     = 1'b0;
    m_pc      = RVEC;
    m_cnt     = 0;
  endfunction

  // One clock cycle: called 1 time unit after a rising edge, returns 1 time unit after the next.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rp,
                       input logic hl, input logic rs, input logic rdy);
    logic        v, f, bad;
    logic [31:0] nx;
    stall = st; redirect = rd; redirect_pc = rp; halt = hl; resume = rs;
    ifc.req_ready = rdy;
    v  = (boot_left == 0) && !m_halt && !st;
    f  = v && rdy;
    nx = m_pc + 32'd4;
    if (f) exp_q.push_back(m_pc);
    @(negedge clk);
    chk("req_valid", {63'h0, ifc.req_valid}, {63'h0, v});
    chk("req_addr",  {32'h0, ifc.req_addr},  {32'h0, m_pc});
    chk("pc_next",   {32'h0, pc_next},       {32'h0, nx});
    chk("fetch_cnt", {60'h0, fetch_cnt},     64'(m_cnt));
    chk("halted",    {63'h0, halted},        {63'h0, m_halt});
    chk("misalign",  {63'h0, misalign},      {63'h0, m_mis});
    @(posedge clk);
    if (f && m_cnt < CNT_MAX) m_cnt++;
`ifdef PC_ALIGN_CHECK_EN
    bad = rd && (rp[1:0] != 2'b00);
`else
    bad = 1'b0;
`endif
    if (bad) begin
      m_pc = RVEC; m_halt = 1'b1; m_mis = 1'b1; boot_left = 0;
    end else begin
      if (rd) m_pc = rp;
      else if (f) m_pc = nx;
      if (boot_left > 0) boot_left--;
      else if (m_halt) begin
        if (rs || rd) m_halt = 1'b0;
      end else if (hl && !rd) m_halt = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.req_ready = 1'b1;
    #1;
    chk("rst_valid",    {63'h0, ifc.req_valid}, 64'h0);
    chk("rst_addr",     {32'h0, ifc.req_addr},  {32'h0, RVEC});
    chk("rst_cnt",      {60'h0, fetch_cnt},     64'h0);
    chk("rst_halted",   {63'h0, halted},        64'h0);
    chk("rst_misalign", {63'h0, misalign},      64'h0);
    model_reset();
    exp_q.delete();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held, rp;
    ifc.req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Boot hold then three sequential fetches
    repeat (5) cycle(0, 0, 0, 0, 0, 1);
    chk("t1_cnt",  {60'h0, fetch_cnt},    64'd3);
    chk("t1_addr", {32'h0, ifc.req_addr}, 64'h200C);

    // Not-ready holds the address
    held = ifc.req_addr;
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    chk("t2_hold", {32'h0, ifc.req_addr}, {32'h0, held});
    chk("t2_cnt",  {60'h0, fetch_cnt},    64'd3);
    cycle(0, 0, 0, 0, 0, 1);
    chk("t2_adv",  {32'h0, ifc.req_addr}, {32'h0, held + 32'd4});

    // Redirect under stall
    cycle(1, 1, 32'h100, 0, 0, 1);
    chk("t3_addr",  {32'h0, ifc.req_addr}, 64'h100);
    chk("t3_valid", {63'h0, ifc.req_valid}, 64'h0);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("t3_after", {32'h0, ifc.req_addr}, 64'h104);

    // Wrap at top of address space
    cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("t4_wrap", {32'h0, ifc.req_addr}, 64'h0);

    // Halt and resume
    cycle(0, 0, 0, 1, 0, 1);
    chk("t5_halted", {63'h0, halted},        64'h1);
    chk("t5_valid",  {63'h0, ifc.req_valid}, 64'h0);
    held = ifc.req_addr;
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 1, 1);
    chk("t5_resumed", {63'h0, halted},       64'h0);
    chk("t5_pc",      {32'h0, ifc.req_addr}, {32'h0, held});

    // Halt wins over resume while running
    cycle(0, 0, 0, 1, 1, 0);
    chk("t5_halt_wins", {63'h0, halted}, 64'h1);
    cycle(0, 0, 0, 0, 1, 0);

    // Misaligned redirect
    cycle(0, 1, 32'h102, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    chk("t6_addr", {32'h0, ifc.req_addr}, {32'h0, RVEC});
    chk("t6_mis",  {63'h0, misalign},     64'h1);
    chk("t6_halt", {63'h0, halted},       64'h1);
    cycle(0, 0, 0, 0, 1, 0);
`else
    chk("t6_addr", {32'h0, ifc.req_addr}, 64'h102);
    chk("t6_mis",  {63'h0, misalign},     64'h0);
`endif

    // Counter saturation
    repeat (20) cycle(0, 0, 0, 0, 0, 1);
    chk("sat_cnt", {60'h0, fetch_cnt}, 64'(CNT_MAX));
    cycle(0, 1, 32'h400, 0, 0, 1);
    chk("sat_redirect_keeps", {60'h0, fetch_cnt}, 64'(CNT_MAX));

    // Reset in the middle of a pending handshake
    cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (4) cycle(0, 0, 0, 0, 0, 1);
    chk("post_rst_cnt", {60'h0, fetch_cnt}, 64'd2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rp = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rp = $urandom();
      if ($urandom_range(0, 9) == 0) rp = 32'hFFFF_FFF4;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rp,
            $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0);
      if (i == 300) do_reset();
    end

    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
